// File: rtl/laser_k.sv
// laser_k: two-circle coverage engine. Loads NPTS points, then searches the 2^W x 2^W grid
// for the pair of circles (squared radius R2) whose union covers the most points.
module laser_k #(
  parameter int          W    = 4,
  parameter int          NPTS = 40,
  parameter int unsigned R2   = 16,
  parameter int          ITER = 3
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        IN_VALID,
  input  logic [W-1:0]                X,
  input  logic [W-1:0]                Y,
  output logic                        BUSY,
  output logic                        DONE,
  output logic [W-1:0]                C1X,
  output logic [W-1:0]                C1Y,
  output logic [W-1:0]                C2X,
  output logic [W-1:0]                C2Y,
  output logic [$clog2(NPTS+1)-1:0]   COVER
);

  localparam int CW = $clog2(NPTS + 1);
  localparam int PW = (NPTS > 1) ? $clog2(NPTS) : 1;
  localparam int RW = $clog2(ITER + 1);
  localparam logic [PW-1:0] LAST_PT    = PW'(NPTS - 1);
  localparam logic [RW-1:0] LAST_ROUND = RW'(ITER - 1);
  localparam logic [W-1:0]  MAX_C      = {W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SRCH1, S_SRCH2, S_REF1, S_REF2, S_FIN
  } state_t;

  state_t state, state_nx;

  logic [W-1:0]  mem_x [NPTS];
  logic [W-1:0]  mem_y [NPTS];

  logic [PW-1:0] pt_idx;
  logic [W-1:0]  cand_x, cand_y;
  logic [CW-1:0] acc;
  logic [CW-1:0] best_cnt;
  logic [W-1:0]  best_x, best_y;
  logic [W-1:0]  c1x, c1y, c2x, c2y;
  logic [CW-1:0] start_cover;
  logic [RW-1:0] round_cnt;
  logic [W-1:0]  out_c1x, out_c1y, out_c2x, out_c2y;
  logic [CW-1:0] out_cover;

  logic          accept;
  logic [W-1:0]  px, py, fix_x, fix_y;
  logic          hit;
  logic [CW-1:0] sum;
  logic          last_pt, last_cand, pass_end, upd, improved;
  logic [CW-1:0] nb_cnt;
  logic [W-1:0]  nb_x, nb_y;

  // Exact integer distance test: |d| is W bits, squares 2W bits, sum 2W+1 bits, no wrap.
  function automatic logic in_circle(input logic [W-1:0] cx, input logic [W-1:0] cy,
                                     input logic [W-1:0] qx, input logic [W-1:0] qy);
    logic [W-1:0]   dx, dy;
    logic [2*W-1:0] ex, ey, sx, sy;
    logic [2*W:0]   d2;
    dx = (cx >= qx) ? cx - qx : qx - cx;
    dy = (cy >= qy) ? cy - qy : qy - cy;
    ex = {{W{1'b0}}, dx};
    ey = {{W{1'b0}}, dy};
    sx = ex * ex;
    sy = ey * ey;
    d2 = {1'b0, sx} + {1'b0, sy};
    return 32'(d2) <= R2;
  endfunction

  assign accept = IN_VALID && (state == S_IDLE || state == S_LOAD);

  // NOTE: sequential state uses non-blocking assignments and a synchronous reset on RST_N.
  always_ff @(posedge CLK) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_nx;
  end

  // One point per cycle against the candidate; fixed circle joins the metric after SRCH1.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    px        = mem_x[pt_idx];
    py        = mem_y[pt_idx];
    fix_x     = (state == S_REF1) ? c2x : c1x;
    fix_y     = (state == S_REF1) ? c2y : c1y;
    hit       = in_circle(cand_x, cand_y, px, py) |
                ((state != S_SRCH1) & in_circle(fix_x, fix_y, px, py));
    sum       = acc + CW'(hit);
    last_pt   = (pt_idx == LAST_PT);
    last_cand = (cand_x == MAX_C) && (cand_y == MAX_C);
    pass_end  = last_pt && last_cand;
    upd       = last_pt && (sum > best_cnt);
    nb_cnt    = upd ? sum    : best_cnt;
    nb_x      = upd ? cand_x : best_x;
    nb_y      = upd ? cand_y : best_y;
    improved  = nb_cnt > start_cover;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (IN_VALID) state_nx = S_LOAD;
      S_LOAD:  if (IN_VALID && last_pt) state_nx = S_SRCH1;
      S_SRCH1: if (pass_end) state_nx = S_SRCH2;
      S_SRCH2: if (pass_end) state_nx = S_REF1;
      S_REF1:  if (pass_end) state_nx = S_REF2;
      S_REF2:  if (pass_end) state_nx = (improved && round_cnt != LAST_ROUND) ? S_REF1 : S_FIN;
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    BUSY = (state != S_IDLE);
    DONE = (state == S_FIN);
  end

  // NOTE: point memory is not reset; a job always rewrites all NPTS entries before reading.
  always_ff @(posedge CLK) begin
    if (accept) begin
      mem_x[pt_idx] <= X;
      mem_y[pt_idx] <= Y;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pt_idx      <= '0;
      cand_x      <= '0;
      cand_y      <= '0;
      acc         <= '0;
      best_cnt    <= '0;
      best_x      <= '0;
      best_y      <= '0;
      c1x         <= '0;
      c1y         <= '0;
      c2x         <= '0;
      c2y         <= '0;
      start_cover <= '0;
      round_cnt   <= '0;
      out_c1x     <= '0;
      out_c1y     <= '0;
      out_c2x     <= '0;
      out_c2y     <= '0;
      out_cover   <= '0;
    end else begin
      case (state)
        S_IDLE, S_LOAD: begin
          if (accept) begin
            if (last_pt) begin
              pt_idx    <= '0;
              cand_x    <= '0;
              cand_y    <= '0;
              acc       <= '0;
              best_cnt  <= '0;
              best_x    <= '0;
              best_y    <= '0;
              round_cnt <= '0;
            end else begin
              pt_idx <= pt_idx + 1'b1;
            end
          end
        end
        S_SRCH1, S_SRCH2, S_REF1, S_REF2: begin
          if (last_pt) begin
            pt_idx   <= '0;
            acc      <= '0;
            best_cnt <= nb_cnt;
            best_x   <= nb_x;
            best_y   <= nb_y;
            cand_x   <= cand_x + 1'b1;
            if (cand_x == MAX_C) cand_y <= cand_y + 1'b1;
          end else begin
            pt_idx <= pt_idx + 1'b1;
            acc    <= sum;
          end
          // End of pass: commit the winner and seed the next pass with its starting centre.
          if (pass_end) begin
            case (state)
              S_SRCH1: begin
                c1x    <= nb_x;
                c1y    <= nb_y;
                best_x <= '0;
                best_y <= '0;
              end
              S_SRCH2: begin
                c2x         <= nb_x;
                c2y         <= nb_y;
                best_x      <= c1x;
                best_y      <= c1y;
                start_cover <= nb_cnt;
              end
              S_REF1: begin
                c1x    <= nb_x;
                c1y    <= nb_y;
                best_x <= c2x;
                best_y <= c2y;
              end
              default: begin
                c2x         <= nb_x;
                c2y         <= nb_y;
                best_x      <= c1x;
                best_y      <= c1y;
                start_cover <= nb_cnt;
                round_cnt   <= round_cnt + 1'b1;
                if (state_nx == S_FIN) begin
                  out_c1x   <= c1x;
                  out_c1y   <= c1y;
                  out_c2x   <= nb_x;
                  out_c2y   <= nb_y;
                  out_cover <= nb_cnt;
                end
              end
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  assign C1X   = out_c1x;
  assign C1Y   = out_c1y;
  assign C2X   = out_c2x;
  assign C2Y   = out_c2y;
  assign COVER = out_cover;

endmodule

// File: tb/tb_laser_k.sv
// tb_laser_k: default-size instance for the (5,5) latency job, plus a reduced-size instance
// driven with directed and random jobs checked against a loop-based coverage model.
`timescale 1ns/1ps
module tb_laser_k;

  localparam int BW = 4, BN = 40, BR2 = 16, BIT = 3, BCW = $clog2(BN + 1);
  localparam int SW = 3, SN = 6,  SR2 = 4,  SIT = 2, SCW = $clog2(SN + 1);
  localparam int SPASS = (1 << (2 * SW)) * SN;

  logic clk = 1'b0;
  logic rst_n;

  logic           b_valid, b_busy, b_done;
  logic [BW-1:0]  b_x, b_y, b_c1x, b_c1y, b_c2x, b_c2y;
  logic [BCW-1:0] b_cover;

  logic           s_valid, s_busy, s_done;
  logic [SW-1:0]  s_x, s_y, s_c1x, s_c1y, s_c2x, s_c2y;
  logic [SCW-1:0] s_cover;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int mx[$];
  int my[$];

  laser_k #(.W(BW), .NPTS(BN), .R2(BR2), .ITER(BIT)) u_big (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(b_valid), .X(b_x), .Y(b_y),
    .BUSY(b_busy), .DONE(b_done), .C1X(b_c1x), .C1Y(b_c1y), .C2X(b_c2x), .C2Y(b_c2y),
    .COVER(b_cover)
  );

  laser_k #(.W(SW), .NPTS(SN), .R2(SR2), .ITER(SIT)) u_small (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(s_valid), .X(s_x), .Y(s_y),
    .BUSY(s_busy), .DONE(s_done), .C1X(s_c1x), .C1Y(s_c1y), .C2X(s_c2x), .C2Y(s_c2y),
    .COVER(s_cover)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit covered(input int cx, input int cy, input int qx, input int qy,
                                 input int r2);
    return (cx - qx) * (cx - qx) + (cy - qy) * (cy - qy) <= r2;
  endfunction

  function automatic int union_count(input int ax, input int ay, input int bx, input int by,
                                     input bit use_b, input int r2);
    int n = 0;
    for (int i = 0; i < mx.size(); i++)
      if (covered(ax, ay, mx[i], my[i], r2) || (use_b && covered(bx, by, mx[i], my[i], r2)))
        n++;
    return n;
  endfunction

  // Best centre over the whole grid in raster order, keeping the seed unless strictly beaten.
  task automatic scan_best(input int side, input int r2, input bit use_fix,
                           input int fx, input int fy, input int sx, input int sy, input int scov,
                           output int bx, output int by, output int bcov);
    int n;
    bx = sx; by = sy; bcov = scov;
    for (int y = 0; y < side; y++)
      for (int x = 0; x < side; x++) begin
        n = union_count(x, y, fx, fy, use_fix, r2);
        if (n > bcov) begin
          bcov = n; bx = x; by = y;
        end
      end
  endtask

  task automatic model_solve(input int side, input int r2, input int iters,
                             output int e1x, output int e1y, output int e2x, output int e2y,
                             output int ecov, output int erounds);
    int start;
    scan_best(side, r2, 1'b0, 0, 0, 0, 0, 0, e1x, e1y, ecov);
    scan_best(side, r2, 1'b1, e1x, e1y, 0, 0, ecov, e2x, e2y, ecov);
    erounds = 0;
    for (int r = 0; r < iters; r++) begin
      start = ecov;
      scan_best(side, r2, 1'b1, e2x, e2y, e1x, e1y, ecov, e1x, e1y, ecov);
      scan_best(side, r2, 1'b1, e1x, e1y, e2x, e2y, ecov, e2x, e2y, ecov);
      erounds++;
      if (ecov == start) break;
    end
  endtask

  task automatic load_small(input int gap, output int t_last);
    for (int i = 0; i < SN; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_x = SW'(mx[i]);
      s_y = SW'(my[i]);
      t_last = cyc;
      if (i < SN - 1)
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          s_valid = 1'b0;
          s_x = SW'($urandom);
          s_y = SW'($urandom);
        end
    end
  endtask

  task automatic run_small(input string name, input int gap, input bit junk);
    int e1x, e1y, e2x, e2y, ecov, er, t_last, lat;
    bit seen;
    model_solve(1 << SW, SR2, SIT, e1x, e1y, e2x, e2y, ecov, er);
    load_small(gap, t_last);
    seen = 1'b0;
    for (int c = 0; c < (2 + 2 * SIT) * SPASS + 20; c++) begin
      @(negedge clk);
      if (s_done) begin
        seen = 1'b1;
        break;
      end
      s_valid = junk && ($urandom_range(3) == 0);
      s_x = SW'($urandom);
      s_y = SW'($urandom);
    end
    s_valid = 1'b0;
    lat = cyc - t_last;
    check({name, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({name, "_latency"}, 32'(lat), 32'((2 + 2 * er) * SPASS + 1));
      check({name, "_busy_at_done"}, 32'(s_busy), 32'd1);
      check({name, "_c1"}, 32'({s_c1x, s_c1y}), 32'((e1x << SW) | e1y));
      check({name, "_c2"}, 32'({s_c2x, s_c2y}), 32'((e2x << SW) | e2y));
      check({name, "_cover"}, 32'(s_cover), 32'(ecov));
      @(negedge clk);
      check({name, "_done_pulse"}, 32'({s_done, s_busy}), 32'd0);
    end
  endtask

  task automatic fill(input int n, input int x, input int y);
    for (int i = 0; i < n; i++) begin
      mx.push_back(x);
      my.push_back(y);
    end
  endtask

  initial begin
    int  t_last, lat, done_cnt;
    bit  seen, busy_seen;

    rst_n = 1'b0;
    b_valid = 1'b0; b_x = '0; b_y = '0;
    s_valid = 1'b0; s_x = '0; s_y = '0;

    // Reset and idle behaviour.
    repeat (2) @(negedge clk);
    check("rst_big_outs", 32'({b_busy, b_done, b_c1x, b_c1y, b_c2x, b_c2y, b_cover}), 32'd0);
    check("rst_small_outs", 32'({s_busy, s_done, s_c1x, s_c1y, s_c2x, s_c2y, s_cover}), 32'd0);
    rst_n = 1'b1;
    busy_seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      busy_seen = busy_seen | b_busy | s_busy | b_done | s_done;
    end
    check("idle_busy", 32'(busy_seen), 32'd0);

    // Default-size job: 40 points at (5,5), one round.
    for (int i = 0; i < BN; i++) begin
      @(negedge clk);
      if (i == 0) check("big_busy_before", 32'(b_busy), 32'd0);
      if (i == 1) check("big_busy_rise", 32'(b_busy), 32'd1);
      b_valid = 1'b1; b_x = 4'd5; b_y = 4'd5;
      t_last = cyc;
    end
    seen = 1'b0;
    for (int c = 0; c < 45000; c++) begin
      @(negedge clk);
      b_valid = 1'b0;
      if (b_done) begin
        seen = 1'b1;
        break;
      end
    end
    lat = cyc - t_last;
    check("big_done_seen", 32'(seen), 32'd1);
    check("big_latency", 32'(lat), 32'd40961);
    check("big_c1", 32'({b_c1x, b_c1y}), 32'({4'd5, 4'd1}));
    check("big_c2", 32'({b_c2x, b_c2y}), 32'd0);
    check("big_cover", 32'(b_cover), 32'd40);
    @(negedge clk);
    check("big_done_pulse", 32'({b_done, b_busy}), 32'd0);

    // Reduced-size directed jobs.
    mx.delete(); my.delete(); fill(SN, 3, 3);
    run_small("same_pt", 0, 1'b0);
    mx.delete(); my.delete(); fill(SN / 2, 1, 1); fill(SN - SN / 2, 6, 6);
    run_small("clusters", 0, 1'b0);
    mx.delete(); my.delete(); fill(SN - 1, 0, 0); fill(1, 4, 0);
    run_small("radius_edge", 0, 1'b0);

    // Random jobs; the first two are repeated with junk strobes and with gapped loading.
    for (int k = 0; k < 4; k++) begin
      mx.delete(); my.delete();
      for (int i = 0; i < SN; i++) begin
        mx.push_back(int'($urandom_range(7)));
        my.push_back(int'($urandom_range(7)));
      end
      run_small($sformatf("rand%0d", k), 0, 1'b0);
      if (k == 0) run_small("rand0_junk", 0, 1'b1);
      if (k == 1) run_small("rand1_gap3", 2, 1'b0);
    end

    // Mid-SRCH2 reset aborts the job, then a fresh job completes.
    mx.delete(); my.delete(); fill(SN, 3, 3);
    run_small("pre_abort", 0, 1'b0);
    load_small(0, t_last);
    repeat (SPASS + 50) begin
      @(negedge clk);
      s_valid = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_outs", 32'({s_busy, s_done, s_c1x, s_c1y, s_c2x, s_c2y, s_cover}), 32'd0);
    done_cnt = 0;
    repeat (1700) begin
      @(negedge clk);
      if (s_done || s_busy) done_cnt++;
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);
    run_small("after_abort", 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
